wb_arb_stage: RTL and testbench

Parametrised write-back stage that collects register-file write requests from NUM_CH result channels (e.g. ALU, load, mul/div), each with a valid/ready handshake. Each channel has a small FIFO. The stage arbitrates between channels, suppresses writes to x0, and drives a single registered register-file write port. It sits between the execute/memory result producers and the register file, replacing the single-channel write-back stage.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_chan_fifo.sv | 56 +++++
 rtl/wb_arb_stage.sv | 143 ++++++++++++++
 tb/tb_wb_arb_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the multi-channel write-back stage.
package wb_pkg;

    localparam int WB_XLEN    = 32;
    localparam int WB_REG_AW  = 5;

    localparam int ARB_FIXED  = 0;
    localparam int ARB_RR     = 1;

    localparam int DROP_CNT_W = 16;

    // One queued register-file write: destination register and result data.
    typedef struct packed {
        logic [WB_REG_AW-1:0] rd;
        logic [WB_XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_chan_fifo.sv
// Single-channel synchronous FIFO holding pending write-back entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_chan_fifo
    import wb_pkg::*;
#(
    parameter int W     = WB_REG_AW + WB_XLEN,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic [W-1:0] mem_r [DEPTH];
    logic         push_s;
    logic         pop_s;

    assign full   = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty  = (wr_ptr_r == rd_ptr_r);
    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign head   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset discards all stored entries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/wb_arb_stage.sv
// Write-back stage: per-channel FIFOs, x0 suppression, fixed or round-robin
// arbitration and a single registered register-file write port.
module wb_arb_stage
    import wb_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int ARB_MODE   = ARB_FIXED
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH-1:0]        i_ch_valid,
    output logic [NUM_CH-1:0]        o_ch_ready,
    input  logic [NUM_CH*REG_AW-1:0] i_ch_rd,
    input  logic [NUM_CH*XLEN-1:0]   i_ch_data,
    output logic                     o_wr_enable,
    output logic [REG_AW-1:0]        o_wr_address,
    output logic [XLEN-1:0]          o_wrdata,
    output logic [NUM_CH-1:0]        o_pending,
    output logic [DROP_CNT_W-1:0]    o_drop_cnt
);

    localparam int EW    = REG_AW + XLEN;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]     full_s;
    logic [NUM_CH-1:0]     empty_s;
    logic [NUM_CH-1:0]     accept_s;
    logic [NUM_CH-1:0]     drop_s;
    logic [NUM_CH-1:0]     push_s;
    logic [NUM_CH-1:0]     pop_s;
    logic [EW-1:0]         head_s [NUM_CH];
    logic [EW-1:0]         head_sel_s;
    logic                  grant_valid_s;
    logic [PTR_W-1:0]      grant_idx_s;
    logic [PTR_W-1:0]      rr_ptr_r;
    logic [DROP_CNT_W:0]   drop_sum_s;
    logic [DROP_CNT_W-1:0] drop_cnt_r;
    logic                  wr_enable_r;
    logic [REG_AW-1:0]     wr_address_r;
    logic [XLEN-1:0]       wrdata_r;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            logic [REG_AW-1:0] ch_rd_s;
            assign ch_rd_s     = i_ch_rd[k*REG_AW +: REG_AW];
            assign accept_s[k] = i_ch_valid[k] & ~full_s[k];
            // Writes to x0 are architecturally void: count them, never queue them.
            assign drop_s[k]   = accept_s[k] & (ch_rd_s == {REG_AW{1'b0}});
            assign push_s[k]   = accept_s[k] & ~drop_s[k];
            assign pop_s[k]    = grant_valid_s & (grant_idx_s == PTR_W'(k));

            wb_chan_fifo #(
                .W     (EW),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .push  (push_s[k]),
                .pop   (pop_s[k]),
                .wdata ({ch_rd_s, i_ch_data[k*XLEN +: XLEN]}),
                .full  (full_s[k]),
                .empty (empty_s[k]),
                .head  (head_s[k])
            );
        end
    endgenerate

    // Grant search: scan from the farthest candidate back to the start point so
    // the nearest non-empty channel (lowest index, or first after the RR pointer) wins.
    always_comb begin
        int               base_v;
        int               cand_v;
        logic [PTR_W-1:0] cand_idx_v;
        base_v        = (ARB_MODE == ARB_RR) ? int'(rr_ptr_r) : 0;
        cand_v        = 0;
        cand_idx_v    = '0;
        grant_valid_s = |(~empty_s);
        grant_idx_s   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand_v      = (base_v + i) % NUM_CH;
            cand_idx_v  = PTR_W'(cand_v);
            grant_idx_s = empty_s[cand_idx_v] ? grant_idx_s : cand_idx_v;
        end
        head_sel_s = head_s[grant_idx_s];
    end

    // Sum of x0 drops this cycle on top of the running count, one extra bit for saturation.
    always_comb begin
        drop_sum_s = {1'b0, drop_cnt_r};
        for (int i = 0; i < NUM_CH; i++) begin
            drop_sum_s = drop_sum_s + {{DROP_CNT_W{1'b0}}, drop_s[i]};
        end
    end

    // Register-file write port: registered grant result, cleared when idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_enable_r  <= 1'b0;
            wr_address_r <= {REG_AW{1'b0}};
            wrdata_r     <= {XLEN{1'b0}};
        end else if (grant_valid_s) begin
            wr_enable_r  <= 1'b1;
            wr_address_r <= head_sel_s[XLEN +: REG_AW];
            wrdata_r     <= head_sel_s[XLEN-1:0];
        end else begin
            wr_enable_r  <= 1'b0;
            wr_address_r <= {REG_AW{1'b0}};
            wrdata_r     <= {XLEN{1'b0}};
        end
    end

    // Round-robin pointer moves past the granted channel; holds when idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_r <= '0;
        end else if (grant_valid_s) begin
            rr_ptr_r <= (grant_idx_s == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx_s + PTR_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Saturating count of discarded x0 writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else begin
            drop_cnt_r <= drop_sum_s[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum_s[DROP_CNT_W-1:0];
        end
    end

    assign o_ch_ready   = ~full_s;
    assign o_pending    = ~empty_s;
    assign o_wr_enable  = wr_enable_r;
    assign o_wr_address = wr_address_r;
    assign o_wrdata     = wrdata_r;
    assign o_drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_wb_arb_stage.sv
// Bench for wb_arb_stage: one fixed-priority and one round-robin instance,
// each with a scoreboard queue of expected register-file writes.
module tb_wb_arb_stage;
    import wb_pkg::*;

    logic        clk;
    logic        rst0, rst1;
    logic [2:0]  v0, v1;
    logic [14:0] rd0, rd1;
    logic [95:0] d0, d1;
    logic [2:0]  ready0, ready1, pend0, pend1;
    logic        en0, en1;
    logic [4:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [15:0] drop0, drop1;

    int errors = 0;
    int checks = 0;
    wb_entry_t q0[$];
    wb_entry_t q1[$];
    wb_entry_t e0, e1;

    wb_arb_stage #(.NUM_CH(3), .XLEN(32), .REG_AW(5), .FIFO_DEPTH(2), .ARB_MODE(ARB_FIXED)) u_dut0 (
        .i_clk(clk), .i_rst(rst0), .i_ch_valid(v0), .o_ch_ready(ready0), .i_ch_rd(rd0),
        .i_ch_data(d0), .o_wr_enable(en0), .o_wr_address(addr0), .o_wrdata(wdata0),
        .o_pending(pend0), .o_drop_cnt(drop0)
    );

    wb_arb_stage #(.NUM_CH(3), .XLEN(32), .REG_AW(5), .FIFO_DEPTH(2), .ARB_MODE(ARB_RR)) u_dut1 (
        .i_clk(clk), .i_rst(rst1), .i_ch_valid(v1), .o_ch_ready(ready1), .i_ch_rd(rd1),
        .i_ch_data(d1), .o_wr_enable(en1), .o_wr_address(addr1), .o_wrdata(wdata1),
        .o_pending(pend1), .o_drop_cnt(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input int k, input logic [4:0] rd, input logic [31:0] data);
        rd0[k*5 +: 5]  = rd;
        d0[k*32 +: 32] = data;
    endtask

    task automatic set1(input int k, input logic [4:0] rd, input logic [31:0] data);
        rd1[k*5 +: 5]  = rd;
        d1[k*32 +: 32] = data;
    endtask

    task automatic exp0(input logic [4:0] rd, input logic [31:0] data);
        wb_entry_t e;
        e.rd = rd;
        e.data = data;
        q0.push_back(e);
    endtask

    task automatic exp1(input logic [4:0] rd, input logic [31:0] data);
        wb_entry_t e;
        e.rd = rd;
        e.data = data;
        q1.push_back(e);
    endtask

    // Scoreboard monitors: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (en0 === 1'b1) begin
            if (q0.size() == 0) begin
                check_val("dut0_unexp_wr", en0, 1'b0);
            end else begin
                e0 = q0.pop_front();
                check_val("dut0_sb_addr", addr0, e0.rd);
                check_val("dut0_sb_data", wdata0, e0.data);
            end
        end
    end

    always @(negedge clk) begin
        if (en1 === 1'b1) begin
            if (q1.size() == 0) begin
                check_val("dut1_unexp_wr", en1, 1'b0);
            end else begin
                e1 = q1.pop_front();
                check_val("dut1_sb_addr", addr1, e1.rd);
                check_val("dut1_sb_data", wdata1, e1.data);
            end
        end
    end

    initial begin
        int j;
        int acc3_edge;
        logic accepted;
        logic ch0_stall;

        // Reset held two cycles with all channels requesting.
        rst0 = 1'b1; rst1 = 1'b1;
        v0 = 3'b111; v1 = 3'b111;
        rd0 = 15'd0; rd1 = 15'd0; d0 = 96'd0; d1 = 96'd0;
        for (int k = 0; k < 3; k++) begin
            set0(k, 5'(k + 1), 32'h5000_0000 + 32'(k));
            set1(k, 5'(k + 1), 32'h6000_0000 + 32'(k));
        end
        step(); step();
        @(negedge clk);
        check_val("rst_wr_en", en0, 1'b0);
        check_val("rst_ready0", ready0, 3'b111);
        check_val("rst_ready1", ready1, 3'b111);
        check_val("rst_drop", drop0, 16'd0);
        check_val("rst_pending", pend0, 3'b000);
        check_val("rst_addr", addr0, 5'd0);
        rst0 = 1'b0; rst1 = 1'b0; v0 = 3'b000; v1 = 3'b000;
        step();
        @(negedge clk);
        check_val("post_rst_wr", en0, 1'b0);

        // Single channel: ch1 rd=5.
        v0 = 3'b010;
        set0(1, 5'd5, 32'hDEAD_BEEF);
        exp0(5'd5, 32'hDEAD_BEEF);
        step();
        v0 = 3'b000;
        @(negedge clk);
        check_val("single_lat", en0, 1'b0);
        check_val("single_pend", pend0, 3'b010);
        step();
        @(negedge clk);
        check_val("single_wr_en", en0, 1'b1);
        check_val("single_addr", addr0, 5'd5);
        check_val("single_data", wdata0, 32'hDEAD_BEEF);
        step();
        @(negedge clk);
        check_val("single_idle", en0, 1'b0);
        check_val("single_pend_clr", pend0, 3'b000);

        // Fixed priority: all three channels push in one cycle.
        v0 = 3'b111;
        for (int k = 0; k < 3; k++) begin
            set0(k, 5'(k + 1), 32'h1111_0000 + 32'(k));
            exp0(5'(k + 1), 32'h1111_0000 + 32'(k));
        end
        step();
        v0 = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check_val("fixed_wr_en", en0, 1'b1);
            check_val("fixed_addr", addr0, 5'(i + 1));
        end
        step();
        @(negedge clk);
        check_val("fixed_idle", en0, 1'b0);

        // Round-robin: each channel sends two back-to-back beats.
        v1 = 3'b111;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 3; k++) begin
                exp1(5'(k + 1), 32'hC0DE_0000 + 32'(b * 16 + k));
            end
        end
        for (int k = 0; k < 3; k++) set1(k, 5'(k + 1), 32'hC0DE_0000 + 32'(k));
        check_val("rr_ready_b0", ready1, 3'b111);
        step();
        for (int k = 0; k < 3; k++) set1(k, 5'(k + 1), 32'hC0DE_0010 + 32'(k));
        @(negedge clk);
        check_val("rr_ready_b1", ready1, 3'b111);
        step();
        v1 = 3'b000;
        @(negedge clk);
        check_val("rr_wr_en", en1, 1'b1);
        check_val("rr_addr", addr1, 5'd1);
        for (int i = 1; i < 6; i++) begin
            step();
            @(negedge clk);
            check_val("rr_wr_en", en1, 1'b1);
            check_val("rr_addr", addr1, 5'((i % 3) + 1));
        end
        step();
        @(negedge clk);
        check_val("rr_idle", en1, 1'b0);

        // Backpressure: ch0 streams and keeps winning, ch2 fills and stalls.
        for (int c = 0; c < 6; c++) exp0(5'd7, 32'h0A00_0000 + 32'(c));
        for (int b = 0; b < 3; b++) exp0(5'd9, 32'h0C00_0000 + 32'(b));
        j = 0;
        acc3_edge = -1;
        ch0_stall = 1'b0;
        step();
        for (int c = 0; c < 20; c++) begin
            v0[0] = (c < 6);
            set0(0, 5'd7, 32'h0A00_0000 + 32'(c));
            v0[2] = (j < 3);
            set0(2, 5'd9, 32'h0C00_0000 + 32'(j));
            @(negedge clk);
            if (c == 2) check_val("bp_ready_low", ready0[2], 1'b0);
            if (c == 7) check_val("bp_still_full", ready0[2], 1'b0);
            if (v0[0] && !ready0[0]) ch0_stall = 1'b1;
            accepted = v0[2] && ready0[2];
            step();
            if (accepted) begin
                j++;
                if (j == 3) acc3_edge = c + 1;
            end
        end
        v0 = 3'b000;
        check_val("bp_third_accept_edge", acc3_edge, 9);
        check_val("bp_ch0_no_stall", ch0_stall, 1'b0);
        check_val("bp_drained", q0.size(), 0);

        // x0 write is dropped and counted.
        v0 = 3'b010;
        set0(1, 5'd0, 32'h0000_1234);
        step();
        v0 = 3'b000;
        @(negedge clk);
        check_val("x0_no_wr", en0, 1'b0);
        check_val("x0_drop_cnt", drop0, 16'd1);
        check_val("x0_pending", pend0, 3'b000);
        step();
        @(negedge clk);
        check_val("x0_no_wr2", en0, 1'b0);

        // Reset with entries in flight: they are discarded, nothing written.
        v0 = 3'b111;
        for (int k = 0; k < 3; k++) set0(k, 5'(k + 4), 32'h7700_0000 + 32'(k));
        step();
        @(negedge clk);
        check_val("mid_pending", pend0, 3'b111);
        rst0 = 1'b1;
        step(); step();
        @(negedge clk);
        check_val("mid_rst_wr", en0, 1'b0);
        check_val("mid_rst_pending", pend0, 3'b000);
        check_val("mid_rst_drop", drop0, 16'd0);
        rst0 = 1'b0;
        v0 = 3'b000;
        step();
        @(negedge clk);
        check_val("mid_post_rst_wr", en0, 1'b0);
        check_val("mid_post_rst_pend", pend0, 3'b000);
        check_val("mid_post_rst_ready", ready0, 3'b111);

        repeat (4) step();
        check_val("q0_left", q0.size(), 0);
        check_val("q1_left", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
